// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor.
//
// decoded_instruction_type is the decoder output seen by the control unit. It is 5 bits wide,
// so codes 16..31 are unassigned. The control unit treats any unassigned code as a NOP.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the K&S data path.
//
// modport master : the control unit. It reads the decoded instruction and flags, and it drives
//                  the strobes.
// modport slave  : the data path / RAM side.
//
// Signals:
//   decoded_instruction  current instruction from the decoder
//   zero_op, neg_op, unsigned_overflow, signed_overflow  registered ALU flags
//   branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0],
//   write_reg_enable, flags_reg_enable, ram_write_enable, halt  control strobes
//   instr_count[15:0]  retired-instruction counter (only with KS_CTRL_INSTR_COUNT_EN)
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
`ifdef KS_CTRL_INSTR_COUNT_EN
  logic [15:0]             instr_count;
`endif

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
`ifdef KS_CTRL_INSTR_COUNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
`ifdef KS_CTRL_INSTR_COUNT_EN
    , input instr_count
`endif
  );

endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the K&S processor.
//
// This block sequences fetch, decode and execute. It owns the RAM wait timing: a fetch and a
// LOAD each hold for MEM_LATENCY cycles.
//
// Parameters:
//   MEM_LATENCY  RAM read latency in cycles, legal range 1..7.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   ctrl   control_unit_if.master. It carries the decoded instruction and the flags in, and
//          the data-path strobes out.
//
// Optional feature (macro KS_CTRL_INSTR_COUNT_EN):
//   When defined, this adds ctrl.instr_count[15:0]. It counts retired instructions, wraps at
//   16 bits, and freezes in halt.
//
// All outputs are Moore-decoded from state_q and wait_q. The one exception is the branch-taken
// decision, which looks at the flags while in the branch state.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master ctrl
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : gen_latency_check
    $error("control_unit: MEM_LATENCY must be in 1..7");
  end

  typedef enum logic [3:0] {
    StInit,
    StFetch,
    StDecode,
    StLoad,
    StStore,
    StMove,
    StAlu,
    StBranch,
    StHalt
  } state_e;

  localparam logic [2:0] LastWait = 3'(MEM_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [2:0]              wait_q, wait_d;
  // Instruction captured in decode; execute states use this copy, not the live decoder.
  decoded_instruction_type instr_q, instr_d;

  logic       wait_last;
  logic       taken;
  logic [1:0] alu_op;

  // Reads this input so that it is consumed; no branch type depends on it.
  logic unused_uov;
  assign unused_uov = ctrl.unsigned_overflow;

  assign wait_last = (wait_q == LastWait);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    instr_d = instr_q;
    unique case (state_q)
      StInit: state_d = StFetch;
      StFetch, StLoad: begin
        if (wait_last) begin
          wait_d  = 3'd0;
          state_d = (state_q == StFetch) ? StDecode : StFetch;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StDecode: begin
        instr_d = ctrl.decoded_instruction;
        case (ctrl.decoded_instruction)
          I_LOAD:                       state_d = StLoad;
          I_STORE:                      state_d = StStore;
          I_MOVE:                       state_d = StMove;
          I_ADD, I_SUB, I_AND, I_OR:    state_d = StAlu;
          I_BRANCH, I_BZERO, I_BNZERO,
          I_BNEG, I_BNNEG, I_BOV,
          I_BNOV:                       state_d = StBranch;
          I_HALT:                       state_d = StHalt;
          default:                      state_d = StFetch;
        endcase
      end
      StStore, StMove, StAlu, StBranch: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      wait_q  <= 3'd0;
      instr_q <= I_NOP;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
    end
  end

  // ALU opcode of the latched instruction
  always_comb begin
    alu_op = 2'b00;
    case (instr_q)
      I_SUB:   alu_op = 2'b11;
      I_AND:   alu_op = 2'b01;
      I_OR:    alu_op = 2'b10;
      default: alu_op = 2'b00;
    endcase
  end

  // Branch condition for the latched branch type, from the flags as they are now
  always_comb begin
    taken = 1'b0;
    case (instr_q)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = ctrl.zero_op;
      I_BNZERO: taken = ~ctrl.zero_op;
      I_BNEG:   taken = ctrl.neg_op;
      I_BNNEG:  taken = ~ctrl.neg_op;
      I_BOV:    taken = ctrl.signed_overflow;
      I_BNOV:   taken = ~ctrl.signed_overflow;
      default:  taken = 1'b0;
    endcase
  end

  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;

  // Output decode
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (state_q)
      StFetch:  ir_enable = wait_last;
      StDecode: pc_enable = 1'b1;
      StLoad: begin
        addr_sel         = 1'b1;
        write_reg_enable = wait_last;
      end
      StStore: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      StMove: begin
        operation        = 2'b10;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      StAlu: begin
        operation        = alu_op;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
      end
      StBranch: begin
        pc_enable = taken;
        branch    = taken;
      end
      StHalt:  halt = 1'b1;
      default: ;
    endcase
  end

  assign ctrl.branch           = branch;
  assign ctrl.pc_enable        = pc_enable;
  assign ctrl.ir_enable        = ir_enable;
  assign ctrl.addr_sel         = addr_sel;
  assign ctrl.c_sel            = c_sel;
  assign ctrl.operation        = operation;
  assign ctrl.write_reg_enable = write_reg_enable;
  assign ctrl.flags_reg_enable = flags_reg_enable;
  assign ctrl.ram_write_enable = ram_write_enable;
  assign ctrl.halt             = halt;

`ifdef KS_CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count_q;
  logic        retire;

  // An instruction retires when it hands control back to fetch. Init->Fetch does not count,
  // and a fetch waiting on RAM stays in fetch, so that does not count either.
  assign retire = (state_d == StFetch) &&
                  (state_q inside {StDecode, StLoad, StStore, StMove, StAlu, StBranch});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= 16'd0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign ctrl.instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit. It runs two instances side by side: dut0 with MEM_LATENCY=3 and
// dut1 with MEM_LATENCY=1.
//
// Each instance has a queue of the output vectors expected on upcoming cycles. When an
// instruction is handed over (on the ir_enable cycle), the queue is extended with that
// instruction's full decode/execute/fetch cycle list. The list is built from the instruction
// timing rules.
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam int unsigned L0 = 3;
  localparam int unsigned L1 = 1;
  localparam int NDIR  = 10;
  localparam int NRAND = 200;

  // Output vector: {branch, pc, ir, addr, c_sel, op[1:0], wr, flags, ram_we, halt}
  localparam logic [10:0] V_BR   = 11'h400;
  localparam logic [10:0] V_PC   = 11'h200;
  localparam logic [10:0] V_IR   = 11'h100;
  localparam logic [10:0] V_ADDR = 11'h080;
  localparam logic [10:0] V_CSEL = 11'h040;
  localparam logic [10:0] V_AND  = 11'h010;
  localparam logic [10:0] V_OR   = 11'h020;
  localparam logic [10:0] V_SUB  = 11'h030;
  localparam logic [10:0] V_WR   = 11'h008;
  localparam logic [10:0] V_FL   = 11'h004;
  localparam logic [10:0] V_RAM  = 11'h002;
  localparam logic [10:0] V_HALT = 11'h001;

  typedef struct packed {
    logic [10:0] o;
    logic        scr;     // ALU execute: the decoder output may be scrambled
    logic        ret;     // first fetch after a retirement
    logic        mid;     // LOAD wait cycle that is not the last
    logic        sticky;  // halt: repeats forever
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  control_unit_if if0 ();
  control_unit_if if1 ();

  control_unit #(.MEM_LATENCY(L0)) dut0 (.clk(clk), .rst_n(rst_n), .ctrl(if0.master));
  control_unit #(.MEM_LATENCY(L1)) dut1 (.clk(clk), .rst_n(rst_n), .ctrl(if1.master));

  logic [4:0]  ins_drv [2];
  logic [3:0]  flg_drv [2];  // {zero, neg, unsigned_ovf, signed_ovf}
  logic [10:0] dut_o   [2];

  assign if0.decoded_instruction = decoded_instruction_type'(ins_drv[0]);
  assign if1.decoded_instruction = decoded_instruction_type'(ins_drv[1]);
  assign {if0.zero_op, if0.neg_op, if0.unsigned_overflow, if0.signed_overflow} = flg_drv[0];
  assign {if1.zero_op, if1.neg_op, if1.unsigned_overflow, if1.signed_overflow} = flg_drv[1];
  assign dut_o[0] = {if0.branch, if0.pc_enable, if0.ir_enable, if0.addr_sel, if0.c_sel,
                     if0.operation, if0.write_reg_enable, if0.flags_reg_enable,
                     if0.ram_write_enable, if0.halt};
  assign dut_o[1] = {if1.branch, if1.pc_enable, if1.ir_enable, if1.addr_sel, if1.c_sel,
                     if1.operation, if1.write_reg_enable, if1.flags_reg_enable,
                     if1.ram_write_enable, if1.halt};
`ifdef KS_CTRL_INSTR_COUNT_EN
  logic [15:0] dut_cnt [2];
  assign dut_cnt[0] = if0.instr_count;
  assign dut_cnt[1] = if1.instr_count;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q0[$];
  ent_t        q1[$];
  logic [15:0] mcnt     [2];
  int          issued   [2];
  int          dir_idx  [2];
  int          hc       [2];
  logic        last_mid [2];
  logic [8:0]  dir      [NDIR];
  logic        force_load = 1'b0;
  logic        force_halt = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [10:0] o);
    ent_t e;
    e   = '0;
    e.o = o;
    return e;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int k, input ent_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int k, output ent_t e);
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete();
    else q1.delete();
  endtask

  function automatic int unsigned lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  // Builds the expected cycles for one instruction, from decode up to and including the next
  // ir_enable cycle.
  task automatic gen(input int unsigned l, input logic [4:0] ins, input logic [3:0] flg,
                     output ent_t seq [16], output int n);
    decoded_instruction_type di;
    logic tk;
    ent_t e;
    di = decoded_instruction_type'(ins);
    tk = 1'b0;
    for (int i = 0; i < 16; i++) seq[i] = '0;
    seq[0] = mk(V_PC);
    n = 1;
    case (di)
      I_LOAD: begin
        for (int i = 0; i < int'(l); i++) begin
          e     = mk((i == int'(l) - 1) ? (V_ADDR | V_WR) : V_ADDR);
          e.mid = (i != int'(l) - 1);
          seq[n] = e;
          n = n + 1;
        end
      end
      I_STORE: begin seq[n] = mk(V_ADDR | V_RAM); n = n + 1; end
      I_MOVE:  begin seq[n] = mk(V_OR | V_CSEL | V_WR); n = n + 1; end
      I_ADD, I_SUB, I_AND, I_OR: begin
        e = mk(V_CSEL | V_WR | V_FL |
               ((di == I_SUB) ? V_SUB : (di == I_AND) ? V_AND : (di == I_OR) ? V_OR : 11'h0));
        e.scr = 1'b1;
        seq[n] = e;
        n = n + 1;
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (di)
          I_BRANCH: tk = 1'b1;
          I_BZERO:  tk = flg[3];
          I_BNZERO: tk = !flg[3];
          I_BNEG:   tk = flg[2];
          I_BNNEG:  tk = !flg[2];
          I_BOV:    tk = flg[0];
          default:  tk = !flg[0];
        endcase
        seq[n] = mk(tk ? (V_BR | V_PC) : 11'h0);
        n = n + 1;
      end
      default: ;
    endcase
    if (di == I_HALT) begin
      e        = mk(V_HALT);
      e.sticky = 1'b1;
      seq[n]   = e;
      n = n + 1;
    end else begin
      for (int i = 0; i < int'(l); i++) begin
        e     = mk((i == int'(l) - 1) ? V_IR : 11'h0);
        e.ret = (i == 0);
        seq[n] = e;
        n = n + 1;
      end
    end
  endtask

  task automatic push_fetch(input int k);
    for (int i = 0; i < int'(lat(k)); i++) qpush(k, mk((i == int'(lat(k)) - 1) ? V_IR : 11'h0));
  endtask

  task automatic pick(input int k, output logic [4:0] ins, output logic [3:0] flg);
    flg = 4'($urandom);
    if (force_halt) begin
      ins = I_HALT;
    end else if (k == 0 && force_load) begin
      ins = I_LOAD;
    end else if (dir_idx[k] < NDIR) begin
      {ins, flg} = dir[dir_idx[k]];
      dir_idx[k]++;
    end else begin
      ins = 5'($urandom_range(0, 20));  // 16..20 are unassigned codes
      if (ins == I_HALT) ins = I_LOAD;
    end
  endtask

  task automatic step(input int k);
    ent_t e;
    ent_t seq [16];
    int n;
    logic [4:0] ins;
    logic [3:0] flg;
    if (qsize(k) == 0) begin
      chk($sformatf("dut%0d model queue empty", k), 32'd0, 32'd1);
      return;
    end
    qpop(k, e);
    if (e.ret) mcnt[k] = mcnt[k] + 16'd1;
    chk($sformatf("dut%0d outputs", k), 32'(dut_o[k]), 32'(e.o));
`ifdef KS_CTRL_INSTR_COUNT_EN
    chk($sformatf("dut%0d instr_count", k), 32'(dut_cnt[k]), 32'(mcnt[k]));
`endif
    last_mid[k] = e.mid;
    if (e.sticky) qpush(k, e);
    if (e.o[8]) begin
      pick(k, ins, flg);
      ins_drv[k] = ins;
      flg_drv[k] = flg;
      issued[k]++;
      gen(lat(k), ins, flg, seq, n);
      for (int i = 0; i < n; i++) qpush(k, seq[i]);
    end
  endtask

  function automatic logic [8:0] d(input decoded_instruction_type i, input logic [3:0] f);
    return {i, f};
  endfunction

  initial begin
    ent_t s [16];
    int   n;
    ent_t fe;
    int   cycles;
    int   phase;
    int   halt_cyc;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ins_drv[k] = 5'd0; flg_drv[k] = 4'd0; mcnt[k] = 16'd0; issued[k] = 0;
      hc[k] = 0; last_mid[k] = 1'b0;
    end
    dir_idx[0] = 0;
    dir_idx[1] = 1;
    dir[0] = d(I_LOAD,   4'b0000);
    dir[1] = d(I_NOP,    4'b0000);
    dir[2] = d(I_ADD,    4'b0000);
    dir[3] = d(I_SUB,    4'b0000);
    dir[4] = d(I_BZERO,  4'b1000);  // taken
    dir[5] = d(I_BZERO,  4'b0111);  // not taken
    dir[6] = d(I_BNNEG,  4'b1011);  // taken
    dir[7] = d(I_BOV,    4'b1110);  // not taken
    dir[8] = d(I_MOVE,   4'b1111);
    dir[9] = d(I_STORE,  4'b0000);

    // Hand-computed expectations for the cycle-list builder
    gen(1, I_NOP, 4'b0, s, n);    chk("model NOP L=1 length", 32'(n), 32'd2);
    gen(3, I_LOAD, 4'b0, s, n);   chk("model LOAD L=3 length", 32'(n), 32'd7);
    chk("model LOAD L=3 cyc1", 32'(s[1].o), 32'h080);
    chk("model LOAD L=3 cyc3", 32'(s[3].o), 32'h088);
    gen(1, I_SUB, 4'b0, s, n);    chk("model SUB L=1 length", 32'(n), 32'd3);
    chk("model SUB exec", 32'(s[1].o), 32'h07C);
    gen(2, I_BZERO, 4'b1000, s, n); chk("model BZERO taken", 32'(s[1].o), 32'h600);
    gen(2, I_BZERO, 4'b0111, s, n); chk("model BZERO not taken", 32'(s[1].o), 32'h000);
    gen(1, I_STORE, 4'b0, s, n);  chk("model STORE exec", 32'(s[1].o), 32'h082);

    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("dut%0d reset outputs", k), 32'(dut_o[k]), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) push_fetch(k);

    cycles = 0;
    phase = 0;
    halt_cyc = 0;
    while (phase != 3 && cycles < 20000) begin
      @(posedge clk);
      #1;
      // The ALU op must come from the copy latched at decode
      for (int k = 0; k < 2; k++) begin
        if (qsize(k) > 0) begin
          fe = qfront(k);
          if (fe.scr) ins_drv[k] = 5'($urandom_range(0, 31));
        end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) step(k);
      cycles++;
      if (phase == 0) begin
        if (issued[0] >= NDIR + NRAND && issued[1] >= NDIR - 1 + NRAND) begin
          force_load = 1'b1;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (last_mid[0]) begin
          #2 rst_n = 1'b0;
          #1;
          for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d outputs at async reset", k), 32'(dut_o[k]), 0);
`ifdef KS_CTRL_INSTR_COUNT_EN
            chk($sformatf("dut%0d instr_count at reset", k), 32'(dut_cnt[k]), 0);
`endif
          end
          repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
              chk($sformatf("dut%0d outputs in reset", k), 32'(dut_o[k]), 0);
          end
          rst_n = 1'b1;
          for (int k = 0; k < 2; k++) begin
            qclear(k);
            push_fetch(k);
            mcnt[k] = 16'd0;
          end
          force_halt = 1'b1;
          phase = 2;
        end
      end else begin
        for (int k = 0; k < 2; k++) if (dut_o[k][0]) hc[k]++;
        halt_cyc++;
        if (halt_cyc == 120) phase = 3;
      end
    end

    if (phase != 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: reached phase %0d after %0d cycles, required phase 3", phase,
               cycles);
    end
    for (int k = 0; k < 2; k++)
      chk($sformatf("dut%0d halt cycles >= 100", k), 32'(hc[k] >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM for the K&S processor. It pairs with the data path: it consumes the decoded instruction and the flag outputs, and it drives every data-path control strobe plus the RAM write strobe.
- It sequences fetch, decode and execute for LOAD, STORE, MOVE, ADD, SUB, AND, OR, all branch types, NOP and HALT.
- It sits beside the data path in the processor top and owns the memory-wait timing.

Parameters:
- MEM_LATENCY, 1, RAM read latency in cycles; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- decoded_instruction  in  decoded_instruction_type  current instruction from the data-path decoder (k_and_s_pkg).
- zero_op  in  1  registered zero flag.
- neg_op  in  1  registered negative flag.
- unsigned_overflow  in  1  registered unsigned overflow flag.
- signed_overflow  in  1  registered signed overflow flag.
- branch  out  1  1 = PC loads the instruction address field; 0 = PC+1.
- pc_enable  out  1  PC update strobe.
- ir_enable  out  1  IR capture strobe.
- addr_sel  out  1  0 = RAM address from PC; 1 = from the instruction address field.
- c_sel  out  1  0 = register write data from RAM; 1 = from ALU.
- operation  out  2  ALU op: 00 add, 01 and, 10 or, 11 sub.
- write_reg_enable  out  1  register file write strobe.
- flags_reg_enable  out  1  flag register capture strobe.
- ram_write_enable  out  1  RAM write strobe.
- halt  out  1  processor halted.

Behaviour:
- Moore FSM; all outputs are decoded combinationally from the state register and the wait counter.
- Any output not listed for a state is 0, and operation defaults to 00.
- Reset: asynchronous on rst_n low. State goes to S_INIT and the wait counter to 0, so every output is 0 immediately, including during reset asserted mid-instruction. No partial write completes after reset asserts.
- S_INIT: one cycle, all outputs 0 -> S_FETCH.
- S_FETCH: lasts MEM_LATENCY cycles, counted by wait_cnt from 0 to MEM_LATENCY-1.
  - addr_sel=0 throughout.
  - ir_enable=1 only on the final cycle; then wait_cnt clears -> S_DECODE.
- S_DECODE: one cycle, pc_enable=1, branch=0 (PC increments). Next state from decoded_instruction:
  - I_LOAD -> S_LOAD; I_STORE -> S_STORE; I_MOVE -> S_MOVE.
  - I_ADD, I_SUB, I_AND, I_OR -> S_ALU.
  - Any branch type -> S_BRANCH.
  - I_HALT -> S_HALT.
  - I_NOP or any unlisted value -> S_FETCH.
- S_LOAD: MEM_LATENCY cycles with addr_sel=1. On the final cycle c_sel=0 and write_reg_enable=1 -> S_FETCH.
- S_STORE: one cycle, addr_sel=1, ram_write_enable=1 -> S_FETCH.
- S_MOVE: one cycle, operation=10, c_sel=1, write_reg_enable=1. Flags are not updated (flags_reg_enable=0) -> S_FETCH.
- S_ALU: one cycle, c_sel=1, write_reg_enable=1, flags_reg_enable=1 -> S_FETCH.
  - operation is 00 for ADD, 11 for SUB, 01 for AND, 10 for OR.
  - operation is latched at S_DECODE so it holds even if the decoder output changes.
- S_BRANCH: one cycle -> S_FETCH. If the branch is taken, pc_enable=1 and branch=1; if not taken, all outputs are 0 and the PC keeps its DECODE increment.
  - I_BRANCH: always taken.
  - I_BZERO / I_BNZERO: taken when zero_op is 1 / 0.
  - I_BNEG / I_BNNEG: taken when neg_op is 1 / 0.
  - I_BOV / I_BNOV: taken when signed_overflow is 1 / 0.
  - Flags are sampled in S_BRANCH.
- S_HALT: halt=1, all other outputs 0. Only reset exits.
- Instruction cycle counts with L=MEM_LATENCY:
  - NOP: L+1.
  - STORE, MOVE, ALU, BRANCH: L+2.
  - LOAD: 2L+1.
- An out-of-range MEM_LATENCY is a compile-time error via an elaboration assertion.

Optional Feature:
- Macro KS_CTRL_INSTR_COUNT_EN.
- When defined, the block adds output instr_count [15:0]:
  - Counts completed instructions; it increments on the cycle the FSM enters S_FETCH from S_DECODE, S_LOAD, S_STORE, S_MOVE, S_ALU or S_BRANCH.
  - Wraps 0xFFFF -> 0x0000.
  - Freezes in S_HALT and resets to 0 asynchronously.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with MEM_LATENCY=1, IR=NOP: S_INIT with all outputs 0, then FETCH with ir_enable=1 in cycle 1, DECODE with pc_enable=1 in cycle 2, back to FETCH in cycle 3.
- ADD then SUB, MEM_LATENCY=1: execute cycle shows operation=00 then 11, each with c_sel=1, write_reg_enable=1, flags_reg_enable=1 for exactly one cycle.
- LOAD with MEM_LATENCY=3: addr_sel=1 for 3 cycles, write_reg_enable=1 and c_sel=0 only on the 3rd; total 7 cycles fetch-to-fetch.
- BZERO with zero_op=1, then BZERO with zero_op=0: first gives pc_enable=1 and branch=1 in S_BRANCH; second gives pc_enable=0 in S_BRANCH. Repeat for BNNEG with neg_op=0 (taken) and BOV with signed_overflow=0 (not taken).
- MOVE then STORE: MOVE gives operation=10 and flags_reg_enable=0; STORE gives ram_write_enable=1 with addr_sel=1 for one cycle and write_reg_enable=0.
- HALT, then rst_n pulsed low mid-S_LOAD in a later run: halt stays 1 for 100 cycles with no strobes; async reset drops all outputs to 0 within the same cycle. With KS_CTRL_INSTR_COUNT_EN, instr_count equals the number of retired instructions and returns to 0 on reset.
